// File: rtl/ddfs_pkg.sv
// Shared DDFS definitions: tuning-word width, loader state encoding and
// helpers for deriving the beat count from the word and bus widths.
package ddfs_pkg;

  localparam int FTW_W = 48;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } loader_state_e;

  function automatic int calc_nbeats(input int data_w, input int bus_w);
    return data_w / bus_w;
  endfunction

  function automatic bit width_ok(input int data_w, input int bus_w);
    return (bus_w > 0) && (bus_w <= data_w) && ((data_w % bus_w) == 0);
  endfunction

endpackage

// File: rtl/ddfs_ftw_loader_if.sv
// Host write channel into the FTW loader: one beat per WrValid&&WrReady,
// WrLast marks the final beat of a tuning-word frame.
interface ddfs_ftw_loader_if #(
  parameter int BUS_W = 8
);

  logic [BUS_W-1:0] WrData;
  logic             WrValid;
  logic             WrLast;
  logic             WrReady;

  modport master (output WrData, output WrValid, output WrLast, input WrReady);
  modport slave  (input WrData, input WrValid, input WrLast, output WrReady);

endinterface

// File: rtl/ddfs_gap_timer.sv
// Idle-gap watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count would reach TIMEOUT (TIMEOUT=0 disables it).
module ddfs_gap_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_d;

  always_comb begin
    gap_d = gap_q;
    if (clear || (TIMEOUT == 0)) begin
      gap_d = '0;
    end else if (enable) begin
      gap_d = gap_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  // Fires on the idle cycle that would make the gap equal TIMEOUT.
  assign expire = (TIMEOUT != 0) && enable && !clear && (gap_q == LIMIT);

endmodule

// File: rtl/ddfs_ftw_loader.sv
// Host-side writer for the DDFS tuning-word load register: assembles MSB-first
// beats into a word, checks framing and gaps, then commits with a 1-cycle strobe.
module ddfs_ftw_loader
  import ddfs_pkg::*;
#(
  parameter int DATA_W      = FTW_W,
  parameter int BUS_W       = 8,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_COMMIT = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  ddfs_ftw_loader_if.slave  wr,
  input  logic              CommitSync,
  output logic [DATA_W-1:0] FtwOut,
  output logic              FtwLoad,
  output logic              Busy,
  output logic              ErrFrame,
  output logic              ErrTimeout
);

  generate
    if (!width_ok(DATA_W, BUS_W)) begin : g_bad_width
      $error("ddfs_ftw_loader: DATA_W must be a non-zero multiple of BUS_W");
    end
  endgenerate

  localparam int NBEATS = calc_nbeats(DATA_W, BUS_W);
  localparam int CNT_W  = $clog2(NBEATS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1);

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] ftw_q, ftw_d;
  logic              load_q, load_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_frame_q, err_frame_d;
  logic              err_timeout_q, err_timeout_d;

  logic accept;
  logic gap_expire;

  assign accept = wr.WrValid && ready_q;

  ddfs_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (accept || (state_q != COLLECT)),
    .enable (state_q == COLLECT),
    .expire (gap_expire)
  );

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    shift_d       = shift_q;
    ftw_d         = ftw_q;
    load_d        = 1'b0;
    err_frame_d   = 1'b0;
    err_timeout_d = 1'b0;

    if (accept) begin
      shift_d = (shift_q << BUS_W) | DATA_W'(wr.WrData);
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (NBEATS == 1) begin
            if (wr.WrLast) begin
              state_d = COMMIT;
              count_d = CNT_W'(1);
            end else begin
              err_frame_d = 1'b1;
            end
          end else if (wr.WrLast) begin
            err_frame_d = 1'b1;
          end else begin
            state_d = COLLECT;
            count_d = CNT_W'(1);
          end
        end
      end

      COLLECT: begin
        // count_q holds the beats already taken, so LAST_IDX means this is the final one.
        if (accept) begin
          if (wr.WrLast && (count_q == LAST_IDX)) begin
            state_d = COMMIT;
            count_d = count_q + CNT_W'(1);
          end else if (wr.WrLast || (count_q == LAST_IDX)) begin
            err_frame_d = 1'b1;
            state_d     = IDLE;
            count_d     = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else if (gap_expire) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
          count_d       = '0;
        end
      end

      COMMIT: begin
        if ((SYNC_COMMIT == 0) || CommitSync) begin
          ftw_d   = shift_q;
          load_d  = 1'b1;
          state_d = IDLE;
          count_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    ready_d = (state_d != COMMIT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      shift_q       <= '0;
      ftw_q         <= '0;
      load_q        <= 1'b0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      err_frame_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      shift_q       <= shift_d;
      ftw_q         <= ftw_d;
      load_q        <= load_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      err_frame_q   <= err_frame_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign wr.WrReady = ready_q;
  assign FtwOut     = ftw_q;
  assign FtwLoad    = load_q;
  assign Busy       = busy_q;
  assign ErrFrame   = err_frame_q;
  assign ErrTimeout = err_timeout_q;

endmodule

// File: tb/tb_ddfs_ftw_loader.sv
// Bench for ddfs_ftw_loader: one immediate-commit instance and one phase-synced
// instance driven from the same host beats, checked against a frame-level model.
module tb_ddfs_ftw_loader;

  localparam int DATA_W  = 48;
  localparam int BUS_W   = 8;
  localparam int NBEATS  = 6;
  localparam int TIMEOUT = 16;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic [BUS_W-1:0]  wr_data = '0;
  logic              wr_valid = 1'b0;
  logic              wr_last = 1'b0;
  logic              commit_sync = 1'b1;

  logic [DATA_W-1:0] ftw_out0, ftw_out1;
  logic              ftw_load0, ftw_load1;
  logic              busy0, busy1;
  logic              err_frame0, err_frame1;
  logic              err_timeout0, err_timeout1;
  logic              ready0, ready1;

  int checks = 0;
  int errors = 0;
  int load_cnt0 = 0;
  int load_cnt1 = 0;
  int frame_cnt = 0;
  int tout_cnt = 0;
  logic [DATA_W-1:0] exp_ftw = '0;
  logic [DATA_W-1:0] load_reg;

  ddfs_ftw_loader_if #(.BUS_W(BUS_W)) bus0 ();
  ddfs_ftw_loader_if #(.BUS_W(BUS_W)) bus1 ();

  assign bus0.WrData  = wr_data;
  assign bus0.WrValid = wr_valid;
  assign bus0.WrLast  = wr_last;
  assign bus1.WrData  = wr_data;
  assign bus1.WrValid = wr_valid;
  assign bus1.WrLast  = wr_last;
  assign ready0 = bus0.WrReady;
  assign ready1 = bus1.WrReady;

  ddfs_ftw_loader #(.DATA_W(DATA_W), .BUS_W(BUS_W), .TIMEOUT(TIMEOUT), .SYNC_COMMIT(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .wr(bus0), .CommitSync(commit_sync),
    .FtwOut(ftw_out0), .FtwLoad(ftw_load0), .Busy(busy0),
    .ErrFrame(err_frame0), .ErrTimeout(err_timeout0)
  );

  ddfs_ftw_loader #(.DATA_W(DATA_W), .BUS_W(BUS_W), .TIMEOUT(TIMEOUT), .SYNC_COMMIT(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .wr(bus1), .CommitSync(commit_sync),
    .FtwOut(ftw_out1), .FtwLoad(ftw_load1), .Busy(busy1),
    .ErrFrame(err_frame1), .ErrTimeout(err_timeout1)
  );

  always #5 Clock = ~Clock;

  // Downstream load register fed by the immediate-commit instance.
  always @(posedge Clock) begin
    if (!Reset) load_reg <= '0;
    else if (ftw_load0) load_reg <= ftw_out0;
  end

  logic              prev_load0 = 1'b0;
  logic              prev_reset = 1'b0;
  logic [DATA_W-1:0] prev_out0 = '0;

  always @(negedge Clock) begin
    if (ftw_load0 === 1'b1) load_cnt0++;
    if (ftw_load1 === 1'b1) load_cnt1++;
    if (err_frame0 === 1'b1) frame_cnt++;
    if (err_timeout0 === 1'b1) tout_cnt++;
    if (ftw_load0 === 1'b1) begin
      checks++;
      if (prev_load0 === 1'b1) begin
        errors++;
        $display("[TB] FAIL load_consecutive: FtwLoad got 1 on two cycles, required single pulse");
      end
    end
    if (Reset && prev_reset && (ftw_out0 !== prev_out0)) begin
      checks++;
      if (ftw_load0 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ftw_stable: FtwOut changed to %h without FtwLoad", ftw_out0);
      end
    end
    prev_load0 = ftw_load0;
    prev_reset = Reset;
    prev_out0  = ftw_out0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic send_beat(input logic [BUS_W-1:0] d, input logic last);
    int guard = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    wr_last  = last;
    while (ready0 !== 1'b1 && guard < 100) begin
      tick(1);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("[TB] FAIL ready_wait: WrReady got %b, required 1 within 100 cycles", ready0);
    end
    tick(1);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] fold(input logic [BUS_W-1:0] q[$]);
    logic [DATA_W-1:0] v = '0;
    foreach (q[i]) v = v * 256 + DATA_W'(q[i]);
    return v;
  endfunction

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) begin
      wr_data = BUS_W'($urandom);
      wr_valid = 1'($urandom);
      wr_last = 1'($urandom);
      commit_sync = 1'($urandom);
      tick(1);
      checks++;
      if ({ftw_out0, ftw_load0, ready0, busy0, err_frame0, err_timeout0,
           ftw_out1, ftw_load1, ready1, busy1, err_frame1, err_timeout1} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got out0=%h ld0=%b rdy0=%b busy0=%b out1=%h rdy1=%b, required all 0",
                 ftw_out0, ftw_load0, ready0, busy0, ftw_out1, ready1);
      end
    end
    wr_valid = 1'b0;
    wr_last = 1'b0;
    commit_sync = 1'b1;
    Reset = 1'b1;
    tick(1);
    checks++;
    if ({ready0, ready1, busy0, busy1} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL reset_release: got rdy0=%b rdy1=%b busy0=%b busy1=%b, required 1 1 0 0",
               ready0, ready1, busy0, busy1);
    end
    exp_ftw = '0;
  endtask

  task automatic test_nominal();
    logic [BUS_W-1:0] beats[NBEATS] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    int base = load_cnt0;
    for (int i = 0; i < NBEATS; i++) send_beat(beats[i], i == NBEATS - 1);
    checks++;
    if ({busy0, ready0, ftw_load0} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL nominal_commit_state: got busy=%b rdy=%b ld=%b, required 1 0 0", busy0, ready0, ftw_load0);
    end
    tick(1);
    checks++;
    if ({ftw_load0, ready0, ftw_out0} !== {1'b1, 1'b1, 48'h0123456789AB}) begin
      errors++;
      $display("[TB] FAIL nominal_load: got ld=%b rdy=%b out=%h, required 1 1 0123456789ab", ftw_load0, ready0, ftw_out0);
    end
    exp_ftw = 48'h0123456789AB;
    tick(1);
    checks++;
    if ({ftw_load0, load_reg} !== {1'b0, exp_ftw}) begin
      errors++;
      $display("[TB] FAIL nominal_loadreg: got ld=%b dout=%h, required 0 %h", ftw_load0, load_reg, exp_ftw);
    end
    checks++;
    if (load_cnt0 - base !== 1) begin
      errors++;
      $display("[TB] FAIL nominal_pulses: got %0d load pulses, required 1", load_cnt0 - base);
    end
  endtask

  task automatic test_framing();
    int base = load_cnt0;
    for (int i = 1; i <= 4; i++) send_beat(BUS_W'($urandom), i == 4);
    checks++;
    if ({err_frame0, busy0} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL early_last: got err=%b busy=%b, required 1 0", err_frame0, busy0);
    end
    tick(1);
    checks++;
    if ({err_frame0, ftw_out0} !== {1'b0, exp_ftw}) begin
      errors++;
      $display("[TB] FAIL early_last_after: got err=%b out=%h, required 0 %h", err_frame0, ftw_out0, exp_ftw);
    end
    for (int i = 1; i <= NBEATS; i++) send_beat(BUS_W'($urandom), 1'b0);
    checks++;
    if ({err_frame0, busy0} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL missing_last: got err=%b busy=%b, required 1 0", err_frame0, busy0);
    end
    send_beat(BUS_W'($urandom), 1'b0);
    checks++;
    if ({err_frame0, busy0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL seventh_beat: got err=%b busy=%b, required 0 1", err_frame0, busy0);
    end
    tick(TIMEOUT);
    checks++;
    if (err_timeout0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL framing_cleanup_timeout: got %b, required 1", err_timeout0);
    end
    tick(1);
    checks++;
    if ({load_cnt0 - base, ftw_out0} !== {32'd0, exp_ftw}) begin
      errors++;
      $display("[TB] FAIL framing_no_load: got %0d loads out=%h, required 0 %h", load_cnt0 - base, ftw_out0, exp_ftw);
    end
  endtask

  task automatic test_timeout();
    logic [BUS_W-1:0] q[$];
    for (int i = 0; i < 3; i++) send_beat(BUS_W'($urandom), 1'b0);
    tick(TIMEOUT - 1);
    checks++;
    if ({err_timeout0, busy0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL timeout_early: got err=%b busy=%b, required 0 1", err_timeout0, busy0);
    end
    tick(1);
    checks++;
    if ({err_timeout0, busy0} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL timeout_fire: got err=%b busy=%b, required 1 0", err_timeout0, busy0);
    end
    tick(1);
    checks++;
    if ({err_timeout0, ftw_out0} !== {1'b0, exp_ftw}) begin
      errors++;
      $display("[TB] FAIL timeout_after: got err=%b out=%h, required 0 %h", err_timeout0, ftw_out0, exp_ftw);
    end
    for (int i = 0; i < NBEATS; i++) begin
      q.push_back(BUS_W'($urandom));
      send_beat(q[i], i == NBEATS - 1);
    end
    tick(1);
    exp_ftw = fold(q);
    checks++;
    if ({ftw_load0, ftw_out0} !== {1'b1, exp_ftw}) begin
      errors++;
      $display("[TB] FAIL timeout_recover: got ld=%b out=%h, required 1 %h", ftw_load0, ftw_out0, exp_ftw);
    end
    tick(1);
  endtask

  task automatic test_sync_commit();
    logic [BUS_W-1:0] q[$];
    int bad = 0;
    commit_sync = 1'b0;
    for (int i = 0; i < NBEATS; i++) begin
      q.push_back(BUS_W'($urandom));
      send_beat(q[i], i == NBEATS - 1);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ready1 !== 1'b0 || ftw_load1 !== 1'b0 || busy1 !== 1'b1) bad++;
    end
    exp_ftw = fold(q);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL sync_hold: got %0d cycles with early load or ready, required 0", bad);
    end
    commit_sync = 1'b1;
    tick(1);
    checks++;
    if ({ftw_load1, ftw_out1} !== {1'b1, exp_ftw}) begin
      errors++;
      $display("[TB] FAIL sync_release: got ld=%b out=%h, required 1 %h", ftw_load1, ftw_out1, exp_ftw);
    end
    tick(1);
    checks++;
    if ({ftw_load1, ready1, busy1} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL sync_after: got ld=%b rdy=%b busy=%b, required 0 1 0", ftw_load1, ready1, busy1);
    end
  endtask

  task automatic test_reset_midframe();
    int base0 = load_cnt0;
    int base1 = load_cnt1;
    for (int i = 0; i < 3; i++) send_beat(BUS_W'($urandom), 1'b0);
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    checks++;
    if ({busy0, ftw_load0, ftw_out0} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_collect: got busy=%b ld=%b out=%h, required all 0", busy0, ftw_load0, ftw_out0);
    end
    exp_ftw = '0;
    tick(1);
    commit_sync = 1'b0;
    for (int i = 0; i < NBEATS; i++) send_beat(BUS_W'($urandom), i == NBEATS - 1);
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    commit_sync = 1'b1;
    checks++;
    if ({busy0, ftw_load0, ftw_out0, busy1, ftw_load1, ftw_out1} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_commit: got busy0=%b out0=%h busy1=%b out1=%h, required all 0",
               busy0, ftw_out0, busy1, ftw_out1);
    end
    tick(3);
    checks++;
    if ({load_cnt0 - base0, load_cnt1 - base1, ftw_out1} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_no_load: got loads %0d/%0d out1=%h, required 0/0 0",
               load_cnt0 - base0, load_cnt1 - base1, ftw_out1);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 40; f++) begin
      logic [BUS_W-1:0] q[$];
      int kind = $urandom_range(0, 4);
      int last_at = (kind <= 1) ? NBEATS : (kind == 2) ? $urandom_range(1, NBEATS - 1) : 0;
      int n = (kind == 4) ? $urandom_range(1, NBEATS - 1) : NBEATS;
      int outcome = 0;
      int bl = load_cnt0, bf = frame_cnt, bt = tout_cnt;
      for (int i = 1; i <= n && outcome == 0; i++) begin
        if (i > 1) begin
          int gap = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2) : $urandom_range(0, 3);
          if (gap >= TIMEOUT) begin
            tick(TIMEOUT);
            outcome = 3;
            tick(gap - TIMEOUT);
          end else begin
            tick(gap);
          end
        end
        if (outcome == 0) begin
          q.push_back(BUS_W'($urandom));
          send_beat(q[$], i == last_at);
          if (i == last_at) outcome = (i == NBEATS) ? 1 : 2;
          else if (i == NBEATS) outcome = 2;
        end
      end
      if (outcome == 0) begin
        tick(TIMEOUT);
        outcome = 3;
      end
      if (outcome == 1) begin
        exp_ftw = fold(q);
        tick(1);
      end
      tick(2);
      checks++;
      if ({load_cnt0 - bl, frame_cnt - bf, tout_cnt - bt} !==
          {32'(outcome == 1), 32'(outcome == 2), 32'(outcome == 3)}) begin
        errors++;
        $display("[TB] FAIL random_events frame %0d: got load/frame/tout %0d/%0d/%0d, required outcome %0d",
                 f, load_cnt0 - bl, frame_cnt - bf, tout_cnt - bt, outcome);
      end
      checks++;
      if ({ftw_out0, busy0} !== {exp_ftw, 1'b0}) begin
        errors++;
        $display("[TB] FAIL random_ftw frame %0d: got out=%h busy=%b, required %h 0", f, ftw_out0, busy0, exp_ftw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_framing();
    test_timeout();
    test_sync_commit();
    test_reset_midframe();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
